// File: rtl/memory_pkg.sv
// Shared types for the RV32 memory stage: access sizes, writeback selects,
// misalignment cause codes, FSM states and the registered output bundle.
package memory_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } ls_size_e;

  typedef enum logic [1:0] {
    WsAlu     = 2'b00,
    WsLoad    = 2'b01,
    WsCsr     = 2'b10,
    WsPcPlus4 = 2'b11
  } write_select_e;

  localparam logic [3:0] EcauseLoadMisaligned  = 4'd4;
  localparam logic [3:0] EcauseStoreMisaligned = 4'd6;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } mem_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] alu_data;
    logic [31:0] csr_data;
    logic [31:0] load_data;
    logic        branch_taken;
    logic [1:0]  write_select;
    logic [4:0]  rd_address;
    logic [11:0] csr_address;
    logic        csr_write;
    logic        mret;
    logic        wfi;
    logic        valid;
    logic [3:0]  ecause;
    logic        exception;
  } mem_out_t;

endpackage

// File: rtl/memory_if.sv
// Data-memory bus between the memory stage (master) and the memory system (slave).
interface memory_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;

  modport master (
    output mem_valid, mem_address, mem_write, mem_byte_enable, mem_store_data,
    input  mem_ready, mem_load_data
  );

  modport slave (
    input  mem_valid, mem_address, mem_write, mem_byte_enable, mem_store_data,
    output mem_ready, mem_load_data
  );
endinterface

// File: rtl/memory_load_store_align.sv
// Byte-lane steering for loads and stores plus misalignment detection.
// MEMORY_MISALIGN_TRAP_EN enables misaligned-access detection; otherwise low address bits are ignored.
module memory_load_store_align
  import memory_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_raw_i,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_offset_i,
  input  logic        ld_signed_i,
  output logic [3:0]  byte_enable_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    byte_enable_o = 4'b1111;
    store_data_o  = store_data_i;
    case (size_i)
      SizeByte: begin
        byte_enable_o = 4'b0001 << addr_lsb_i;
        store_data_o  = {4{store_data_i[7:0]}};
      end
      SizeHalf: begin
        byte_enable_o = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
        store_data_o  = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = load_raw_i[7:0];
    unique case (ld_offset_i)
      2'd0: ld_byte = load_raw_i[7:0];
      2'd1: ld_byte = load_raw_i[15:8];
      2'd2: ld_byte = load_raw_i[23:16];
      2'd3: ld_byte = load_raw_i[31:24];
    endcase
    ld_half     = ld_offset_i[1] ? load_raw_i[31:16] : load_raw_i[15:0];
    load_data_o = load_raw_i;
    case (ld_size_i)
      SizeByte: load_data_o = {{24{ld_signed_i & ld_byte[7]}}, ld_byte};
      SizeHalf: load_data_o = {{16{ld_signed_i & ld_half[15]}}, ld_half};
      default:  ;
    endcase
  end

`ifdef MEMORY_MISALIGN_TRAP_EN
  assign misaligned_o = ((size_i == SizeHalf) & addr_lsb_i[0]) |
                        ((size_i == SizeWord) & (addr_lsb_i != 2'b00));
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/memory.sv
// RV32 memory pipeline stage: issues data-bus requests, waits/holds across stalls, registers results.
// MEMORY_MISALIGN_TRAP_EN turns misaligned half/word accesses into exceptions (cause 4/6).
module memory
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        branch_taken_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        load_signed_in,
  input  logic        csr_write_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [1:0]  load_store_size_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall,
  input  logic        invalidate,
  memory_if.master    bus,
  output logic        mem_busy,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic        branch_taken_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic        csr_write_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic [31:0] load_data_out,
  output logic        valid_out,
  output logic [3:0]  ecause_out,
  output logic        exception_out
);

  mem_state_e  state_q, state_d;
  mem_out_t    out_q, out_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic        kill_q, kill_d;
  logic [29:0] req_word_q, req_word_d;
  logic        req_write_q, req_write_d;
  logic [3:0]  req_be_q, req_be_d;
  logic [31:0] req_sdata_q, req_sdata_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [1:0]  req_offset_q, req_offset_d;
  logic        req_signed_q, req_signed_d;

  logic        idle, mis_raw, misaligned, eligible, mem_valid, take;
  logic [1:0]  ld_size, ld_offset;
  logic        ld_signed;
  logic [3:0]  cur_be;
  logic [31:0] cur_sdata, load_ext, load_val;

  assign idle = (state_q == StIdle);

  // Once issued, lane selection must follow the latched request, not the live inputs.
  assign ld_size   = idle ? load_store_size_in : req_size_q;
  assign ld_offset = idle ? alu_data_in[1:0] : req_offset_q;
  assign ld_signed = idle ? load_signed_in : req_signed_q;

  memory_load_store_align u_align (
    .size_i        (load_store_size_in),
    .addr_lsb_i    (alu_data_in[1:0]),
    .store_data_i  (rs2_data_in),
    .load_raw_i    (bus.mem_load_data),
    .ld_size_i     (ld_size),
    .ld_offset_i   (ld_offset),
    .ld_signed_i   (ld_signed),
    .byte_enable_o (cur_be),
    .store_data_o  (cur_sdata),
    .load_data_o   (load_ext),
    .misaligned_o  (mis_raw)
  );

  assign misaligned = mis_raw & (load_in | store_in);
  assign eligible   = valid_in & (load_in | store_in) & ~exception_in & ~invalidate & ~misaligned;

  always_comb begin
    mem_valid = 1'b0;
    case (state_q)
      StIdle:  mem_valid = eligible;
      StWait:  mem_valid = 1'b1;
      default: mem_valid = 1'b0;
    endcase
    mem_valid = mem_valid & ~reset;
  end

  assign bus.mem_valid       = mem_valid;
  assign bus.mem_address     = idle ? {alu_data_in[31:2], 2'b00} : {req_word_q, 2'b00};
  assign bus.mem_write       = idle ? store_in : req_write_q;
  assign bus.mem_byte_enable = idle ? cur_be : req_be_q;
  assign bus.mem_store_data  = idle ? cur_sdata : req_sdata_q;
  assign mem_busy            = mem_valid & ~bus.mem_ready;

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    load_buf_d   = load_buf_q;
    req_word_d   = req_word_q;
    req_write_d  = req_write_q;
    req_be_d     = req_be_q;
    req_sdata_d  = req_sdata_q;
    req_size_d   = req_size_q;
    req_offset_d = req_offset_q;
    req_signed_d = req_signed_q;
    case (state_q)
      StIdle: begin
        req_word_d   = alu_data_in[31:2];
        req_write_d  = store_in;
        req_be_d     = cur_be;
        req_sdata_d  = cur_sdata;
        req_size_d   = load_store_size_in;
        req_offset_d = alu_data_in[1:0];
        req_signed_d = load_signed_in;
        kill_d       = 1'b0;
        if (mem_valid && !bus.mem_ready) begin
          state_d = StWait;
        end else if (mem_valid && stall) begin
          state_d    = StHold;
          load_buf_d = load_ext;
        end
      end
      StWait: begin
        // Invalidate cannot withdraw an issued request; remember it to squash the result.
        kill_d = kill_q | invalidate;
        if (bus.mem_ready) begin
          state_d    = stall ? StHold : StIdle;
          load_buf_d = load_ext;
        end
      end
      StHold: begin
        kill_d = kill_q | invalidate;
        if (!stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    take     = 1'b0;
    load_val = load_ext;
    case (state_q)
      StIdle: take = ~mem_valid | bus.mem_ready;
      StWait: take = bus.mem_ready & ~kill_q;
      StHold: begin
        take     = ~kill_q;
        load_val = load_buf_q;
      end
      default: take = 1'b0;
    endcase
    take  = take & valid_in & ~invalidate;
    out_d = out_q;
    if (!stall) begin
      out_d.valid = 1'b0;
      if (take) begin
        out_d.pc           = pc_in;
        out_d.next_pc      = next_pc_in;
        out_d.alu_data     = alu_data_in;
        out_d.csr_data     = csr_data_in;
        out_d.load_data    = load_val;
        out_d.branch_taken = branch_taken_in;
        out_d.write_select = write_select_in;
        out_d.rd_address   = rd_address_in;
        out_d.csr_address  = csr_address_in;
        out_d.csr_write    = csr_write_in;
        out_d.mret         = mret_in;
        out_d.wfi          = wfi_in;
        out_d.valid        = 1'b1;
        out_d.exception    = exception_in | misaligned;
        out_d.ecause       = ecause_in;
        if (!exception_in && misaligned) begin
          out_d.ecause = load_in ? EcauseLoadMisaligned : EcauseStoreMisaligned;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      out_q        <= '0;
      load_buf_q   <= '0;
      kill_q       <= 1'b0;
      req_word_q   <= '0;
      req_write_q  <= 1'b0;
      req_be_q     <= '0;
      req_sdata_q  <= '0;
      req_size_q   <= '0;
      req_offset_q <= '0;
      req_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      load_buf_q   <= load_buf_d;
      kill_q       <= kill_d;
      req_word_q   <= req_word_d;
      req_write_q  <= req_write_d;
      req_be_q     <= req_be_d;
      req_sdata_q  <= req_sdata_d;
      req_size_q   <= req_size_d;
      req_offset_q <= req_offset_d;
      req_signed_q <= req_signed_d;
    end
  end

  assign pc_out           = out_q.pc;
  assign next_pc_out      = out_q.next_pc;
  assign alu_data_out     = out_q.alu_data;
  assign csr_data_out     = out_q.csr_data;
  assign load_data_out    = out_q.load_data;
  assign branch_taken_out = out_q.branch_taken;
  assign write_select_out = out_q.write_select;
  assign rd_address_out   = out_q.rd_address;
  assign csr_address_out  = out_q.csr_address;
  assign csr_write_out    = out_q.csr_write;
  assign mret_out         = out_q.mret;
  assign wfi_out          = out_q.wfi;
  assign valid_out        = out_q.valid;
  assign ecause_out       = out_q.ecause;
  assign exception_out    = out_q.exception;

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for the memory stage: lane steering, wait states, hold, invalidate, reset.
module tb_memory;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
  logic        branch_taken_in, load_in, store_in, load_signed_in, csr_write_in;
  logic        mret_in, wfi_in, valid_in, exception_in, stall, invalidate;
  logic [1:0]  load_store_size_in, write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic [3:0]  ecause_in;
  logic        mem_busy;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic        branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic [3:0]  ecause_out;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;
  int r0;

  memory_if bus ();

  memory dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
    .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
    .load_signed_in(load_signed_in), .csr_write_in(csr_write_in), .mret_in(mret_in),
    .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
    .load_store_size_in(load_store_size_in), .write_select_in(write_select_in),
    .rd_address_in(rd_address_in), .csr_address_in(csr_address_in), .ecause_in(ecause_in),
    .stall(stall), .invalidate(invalidate), .bus(bus), .mem_busy(mem_busy),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .branch_taken_out(branch_taken_out),
    .write_select_out(write_select_out), .rd_address_out(rd_address_out),
    .csr_address_out(csr_address_out), .csr_write_out(csr_write_out), .mret_out(mret_out),
    .wfi_out(wfi_out), .load_data_out(load_data_out), .valid_out(valid_out),
    .ecause_out(ecause_out), .exception_out(exception_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_valid) req_cnt <= req_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    pc_in = '0; next_pc_in = '0; alu_data_in = '0; rs2_data_in = '0; csr_data_in = '0;
    branch_taken_in = 0; load_in = 0; store_in = 0; load_signed_in = 0; csr_write_in = 0;
    mret_in = 0; wfi_in = 0; valid_in = 0; exception_in = 0; stall = 0; invalidate = 0;
    load_store_size_in = '0; write_select_in = '0; rd_address_in = '0;
    csr_address_in = '0; ecause_in = '0;
  endtask

  task automatic op(input logic ld, input logic st, input logic sgn, input logic [1:0] size,
                    input logic [31:0] addr, input logic [31:0] rs2);
    valid_in = 1; load_in = ld; store_in = st; load_signed_in = sgn;
    load_store_size_in = size; alu_data_in = addr; rs2_data_in = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    reset = 1; bus.mem_ready = 0; bus.mem_load_data = '0;
    step(); step();
    check_eq("rst_valid_out", valid_out, 0);
    check_eq("rst_mem_valid", bus.mem_valid, 0);
    check_eq("rst_pc_out", pc_out, 0);
    check_eq("rst_load_data", load_data_out, 0);
    check_eq("rst_exception", exception_out, 0);
    reset = 0;

    // lb signed, zero-wait
    op(1, 0, 1, SizeByte, 32'h1003, 0); pc_in = 32'h100;
    bus.mem_ready = 1; bus.mem_load_data = 32'h80FF_FF00;
    #1;
    check_eq("lb_mem_valid", bus.mem_valid, 1);
    check_eq("lb_addr", bus.mem_address, 32'h1000);
    check_eq("lb_be", bus.mem_byte_enable, 4'b1000);
    check_eq("lb_write", bus.mem_write, 0);
    check_eq("lb_busy", mem_busy, 0);
    step();
    check_eq("lb_valid_out", valid_out, 1);
    check_eq("lb_data", load_data_out, 32'hFFFF_FF80);
    check_eq("lb_pc", pc_out, 32'h100);

    // sh replicated
    op(0, 1, 0, SizeHalf, 32'h2002, 32'h0000_BEEF);
    #1;
    check_eq("sh_addr", bus.mem_address, 32'h2000);
    check_eq("sh_be", bus.mem_byte_enable, 4'b1100);
    check_eq("sh_sdata", bus.mem_store_data, 32'hBEEF_BEEF);
    check_eq("sh_write", bus.mem_write, 1);
    step();
    check_eq("sh_valid_out", valid_out, 1);

    op(1, 0, 0, SizeHalf, 32'h2002, 0); bus.mem_load_data = 32'h1234_8765;
    step();
    check_eq("lhu_data", load_data_out, 32'h0000_1234);
    op(1, 0, 1, SizeHalf, 32'h2000, 0);
    step();
    check_eq("lh_data", load_data_out, 32'hFFFF_8765);

    // lw at 0x1001
    op(1, 0, 0, SizeWord, 32'h1001, 0); bus.mem_load_data = 32'hDEAD_BEEF;
    #1;
`ifdef MEMORY_MISALIGN_TRAP_EN
    check_eq("lw_mis_mem_valid", bus.mem_valid, 0);
    step();
    check_eq("lw_mis_exc", exception_out, 1);
    check_eq("lw_mis_cause", ecause_out, 4);
    check_eq("lw_mis_valid", valid_out, 1);
    op(0, 1, 0, SizeWord, 32'h2002, 32'h1);
    #1;
    check_eq("sw_mis_mem_valid", bus.mem_valid, 0);
    step();
    check_eq("sw_mis_cause", ecause_out, 6);
`else
    check_eq("lw_una_addr", bus.mem_address, 32'h1000);
    check_eq("lw_una_be", bus.mem_byte_enable, 4'b1111);
    step();
    check_eq("lw_una_data", load_data_out, 32'hDEAD_BEEF);
    check_eq("lw_una_exc", exception_out, 0);
`endif

    // exception passes through with no bus request
    op(1, 0, 0, SizeWord, 32'h3000, 0); exception_in = 1; ecause_in = 4'd2;
    #1;
    check_eq("exc_mem_valid", bus.mem_valid, 0);
    step();
    check_eq("exc_out", exception_out, 1);
    check_eq("exc_cause", ecause_out, 2);
    check_eq("exc_valid", valid_out, 1);

    // three wait states
    clear_in(); bus.mem_ready = 0; bus.mem_load_data = '0;
    step();
    check_eq("gap_valid", valid_out, 0);
    op(1, 0, 0, SizeWord, 32'h3000, 0); pc_in = 32'h300;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("wait_busy%0d", i), mem_busy, 1);
      check_eq($sformatf("wait_addr%0d", i), bus.mem_address, 32'h3000);
      check_eq($sformatf("wait_vout%0d", i), valid_out, 0);
      step();
      alu_data_in = 32'h0000_5554;
      #1;
    end
    alu_data_in = 32'h3000; bus.mem_ready = 1; bus.mem_load_data = 32'h1122_3344;
    #1;
    check_eq("wait_done_busy", mem_busy, 0);
    check_eq("wait_done_mv", bus.mem_valid, 1);
    step();
    check_eq("wait_vout", valid_out, 1);
    check_eq("wait_data", load_data_out, 32'h1122_3344);
    check_eq("wait_pc", pc_out, 32'h300);

    // completion under stall goes to HOLD
    clear_in();
    step();
    op(1, 0, 0, SizeWord, 32'h4000, 0); pc_in = 32'h400; stall = 1;
    bus.mem_ready = 1; bus.mem_load_data = 32'hCAFE_F00D;
    r0 = req_cnt;
    #1;
    check_eq("hold_req", bus.mem_valid, 1);
    step();
    bus.mem_ready = 0; bus.mem_load_data = '0;
    #1;
    check_eq("hold_mv0", bus.mem_valid, 0);
    check_eq("hold_vout0", valid_out, 0);
    step();
    check_eq("hold_mv1", bus.mem_valid, 0);
    stall = 0;
    #1;
    check_eq("hold_mv2", bus.mem_valid, 0);
    step();
    check_eq("hold_vout", valid_out, 1);
    check_eq("hold_data", load_data_out, 32'hCAFE_F00D);
    check_eq("hold_pc", pc_out, 32'h400);
    check_eq("hold_nreq", req_cnt - r0, 1);

    // invalidate during wait squashes the result
    op(1, 0, 0, SizeWord, 32'h6000, 0); pc_in = 32'h600;
    #1;
    step();
    invalidate = 1;
    #1;
    check_eq("inv_mv", bus.mem_valid, 1);
    step();
    invalidate = 0; bus.mem_ready = 1; bus.mem_load_data = 32'h99;
    step();
    check_eq("inv_vout", valid_out, 0);
    bus.mem_ready = 0;

    // reset in WAIT
    op(1, 0, 0, SizeWord, 32'h5000, 0); pc_in = 32'h500;
    #1;
    step();
    check_eq("rstw_busy", mem_busy, 1);
    reset = 1;
    step();
    check_eq("rstw_mv", bus.mem_valid, 0);
    check_eq("rstw_vout", valid_out, 0);
    check_eq("rstw_pc", pc_out, 0);
    reset = 0; clear_in();
    step();
    check_eq("rstw_mv_after", bus.mem_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have no parameters; all widths fixed for RV32.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc/next_pc/alu_data/rs2_data/csr_data_in  in  32 each  execute results; alu_data is the effective address.
REQ-005 branch_taken/load/store/load_signed/csr_write/mret/wfi/valid/exception_in  in  1 each  execute control.
REQ-006 load_store_size_in  in  2  00 byte, 01 half, 10 word.
REQ-007 write_select_in 2, rd_address_in 5, csr_address_in 12, ecause_in 4  in  writeback control.
REQ-008 stall, invalidate  in  1 each  from hazard unit.
REQ-009 mem_valid  out  1  bus request.
REQ-010 mem_ready  in  1  bus completes request this cycle.
REQ-011 mem_address  out  32; mem_write out 1; mem_byte_enable out 4; mem_store_data out 32.
REQ-012 mem_load_data  in  32  read data, valid with mem_ready.
REQ-013 mem_busy  out  1  to hazard: access pending, stage must stall.
REQ-014 *_out  out  registered copies of pc, next_pc, alu_data, csr_data, branch_taken, write_select, rd_address, csr_address, csr_write, mret, wfi; plus load_data_out 32, valid_out 1, ecause_out 4, exception_out 1.

Function
REQ-015 Eligible = valid_in & (load_in|store_in) & !exception_in & !invalidate & !misaligned.
REQ-016 FSM states IDLE, WAIT, HOLD; mem_valid = eligible in IDLE, 1 in WAIT, 0 in HOLD.
REQ-017 IDLE: mem_valid & !mem_ready -> WAIT; mem_valid & mem_ready & stall -> HOLD (buffer load data); else stay.
REQ-018 WAIT: mem_address/write/byte_enable/store_data held stable; invalidate does not withdraw request; mem_ready -> HOLD if stall, else IDLE.
REQ-019 HOLD: no new request; !stall -> IDLE, outputs take buffered data.
REQ-020 mem_busy = mem_valid & !mem_ready.
REQ-021 mem_address = {alu_data_in[31:2], 2'b00}; mem_write = store_in.
REQ-022 byte_enable: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111.
REQ-023 mem_store_data: byte replicated x4, half replicated x2, word as is.
REQ-024 Load data: lane selected by a[1:0], sign-extended if load_signed_in, else zero-extended; zero-wait loads use mem_load_data directly.
REQ-025 Output update only when !stall: valid_out <= 0; if valid_in & !invalidate and (no access, or access completing/held) copy fields, valid_out <= 1.
REQ-026 exception_out/ecause_out: exception_in passes through; else misaligned load -> 4, misaligned store -> 6.
REQ-027 Invalidated instruction whose access completes produces valid_out = 0.
REQ-028 Latency: one cycle with zero-wait bus; +1 per wait cycle.

Reset
REQ-029 Reset: state IDLE, mem_valid 0, all *_out 0, buffered data 0.
REQ-030 Reset in WAIT/HOLD drops request next cycle; bus is reset concurrently.

Configuration
REQ-031 MEMORY_MISALIGN_TRAP_EN defined: misaligned = (half & a[0]) | (word & a[1:0]!=0), traps per REQ-026, no bus request.
REQ-032 Undefined: misaligned = 0; address bits below access size ignored; never ecause 4/6.

Structure
REQ-033 Shared package: size encodings, write_select encodings, ecause constants (4, 6), FSM state enum.
REQ-034 One sub-module load_store_align: byte_enable, store replication, load extraction/extension, misalign detect.

Verification
REQ-035 lb signed, alu_data 0x1003, mem_load_data 0x80FFFF00, ready same cycle -> byte_enable 1000, load_data_out 0xFFFFFF80, valid_out 1 next cycle.
REQ-036 sh, alu_data 0x2002, rs2 0x0000BEEF -> address 0x2000, byte_enable 1100, store_data 0xBEEFBEEF, mem_write 1.
REQ-037 lw at 0x1001: with macro -> mem_valid 0, exception_out 1, ecause_out 4; without -> address 0x1000, byte_enable 1111.
REQ-038 mem_ready low 3 cycles -> mem_busy high 3 cycles, request stable, valid_out on cycle after ready.
REQ-039 mem_ready while stall=1 -> HOLD, exactly one request, load data emerges when stall drops.
REQ-040 reset asserted in WAIT -> mem_valid 0, valid_out 0 next cycle.
